muldiv_sequencer: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Accepts the five-bit ALU control code from the decoder for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sequences a 32-step shift-add multiply or restoring divide, then applies sign correction.
- Raises busy so the pipeline stalls any HI/LO consumer until the result is committed.

---
 rtl/muldiv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_FAST_MULT_EN for single-cycle MULT/MULTU; DIV/DIVU stay iterative.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = $clog2(W) + 1;

    localparam logic [4:0] OP_MULTU = 5'b00111;
    localparam logic [4:0] OP_MULT  = 5'b01000;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MTHI  = 5'b10001;
    localparam logic [4:0] OP_MTLO  = 5'b10010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    mcand;
    logic [W-1:0]    rem;
    logic [W-1:0]    quo;
    logic [W-1:0]    dvsr;
    logic            neg_q;
    logic            neg_r;
    logic            is_div;

    // Operand magnitudes and sign flags for the incoming instruction
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;

    assign is_signed = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
    assign a_neg     = is_signed & srca[W-1];
    assign b_neg     = is_signed & srcb[W-1];
    assign a_mag     = a_neg ? (~srca + W'(1)) : srca;
    assign b_mag     = b_neg ? (~srcb + W'(1)) : srcb;

    // One shift-add step: conditional add into the upper half, then shift right
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;

    assign mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, prod[W-1:1]};

    // One restoring step; the true difference always fits in W bits when taken
    logic [W:0]      rem_sh;
    logic            div_ok;
    logic [W-1:0]    rem_sub;

    assign rem_sh  = {rem, quo[W-1]};
    assign div_ok  = (rem_sh >= {1'b0, dvsr});
    assign rem_sub = rem_sh[W-1:0] - dvsr;

    logic [2*W-1:0]  mul_res;
    logic [W-1:0]    quo_res;
    logic [W-1:0]    rem_res;

    assign mul_res = neg_q ? (~prod + (2*W)'(1)) : prod;
    assign quo_res = neg_q ? (~quo + W'(1)) : quo;
    assign rem_res = neg_r ? (~rem + W'(1)) : rem;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*W-1:0]  fast_prod;
    logic [2*W-1:0]  fast_res;

    assign fast_prod = (2*W)'(a_mag) * (2*W)'(b_mag);
    assign fast_res  = (a_neg ^ b_neg) ? (~fast_prod + (2*W)'(1)) : fast_prod;
`endif

    assign busy = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (alucontrol)
                            OP_MULTU, OP_MULT: begin
`ifdef MULDIV_FAST_MULT_EN
                                {hi, lo} <= fast_res;
                                done     <= 1'b1;
                                state    <= S_DONE;
`else
                                prod   <= {{W{1'b0}}, b_mag};
                                mcand  <= a_mag;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= 1'b0;
                                is_div <= 1'b0;
                                cnt    <= '0;
                                state  <= S_MUL;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                quo    <= a_mag;
                                dvsr   <= b_mag;
                                rem    <= '0;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                is_div <= 1'b1;
                                cnt    <= '0;
                                state  <= S_DIV;
                            end
                            OP_MTHI: hi <= srca;
                            OP_MTLO: lo <= srca;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) state <= S_FIX;
                end
                S_DIV: begin
                    rem  <= div_ok ? rem_sub : rem_sh[W-1:0];
                    quo  <= {quo[W-2:0], div_ok};
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= rem_res;
                        lo <= quo_res;
                    end else begin
                        {hi, lo} <= mul_res;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (default iterative build) with a HI/LO scoreboard.
module tb_muldiv_sequencer;

    localparam int unsigned W   = 32;
    localparam int          LAT = 34;

    localparam logic [4:0] OP_MULTU = 5'b00111;
    localparam logic [4:0] OP_MULT  = 5'b01000;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MTHI  = 5'b10001;
    localparam logic [4:0] OP_MTLO  = 5'b10010;

    logic         clk;
    logic         reset;
    logic         start;
    logic [4:0]   alucontrol;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    int           passed = 0;
    int           failed = 0;
    int           total  = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one mul/div op; optionally raise another start at local cycle inj_k.
    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int inj_k, input logic [4:0] inj_op,
                          input logic [W-1:0] inj_a);
        exp_t e;
        @(negedge clk);
        sb.push_back('{hi: eh, lo: el});
        alucontrol = op;
        srca       = a;
        srcb       = b;
        start      = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            chk($sformatf("%s busy@%0d", tag, k), 64'(busy), 64'(k < LAT));
            chk($sformatf("%s done@%0d", tag, k), 64'(done), 64'(k == LAT));
            if (k == LAT) begin
                e = sb.pop_front();
                model_hi = e.hi;
                model_lo = e.lo;
            end
            if (k < LAT || k == LAT + 2)
                chk($sformatf("%s hilo@%0d", tag, k), {hi, lo}, {model_hi, model_lo});
            if (k == inj_k) begin
                start      = 1'b1;
                alucontrol = inj_op;
                srca       = inj_a;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic move(input string tag, input logic [4:0] op, input logic [W-1:0] a);
        @(negedge clk);
        alucontrol = op;
        srca       = a;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (op == OP_MTHI) model_hi = a;
        if (op == OP_MTLO) model_lo = a;
        chk({tag, " hi"},   64'(hi),   64'(model_hi));
        chk({tag, " lo"},   64'(lo),   64'(model_lo));
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        alucontrol = '0;
        srca       = '0;
        srcb       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset hi",   64'(hi),   64'd0);
        chk("reset lo",   64'(lo),   64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 0, 5'd0, '0);
        // MTLO raised in the DONE cycle must be dropped
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT, OP_MTLO, 32'hDEAD_BEEF);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 0, 5'd0, '0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 5'd0, '0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 0, 5'd0, '0);
        run_op("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0,
               32'h1234_5678, 32'hFFFF_FFFF, 0, 5'd0, '0);
        // MTHI while busy is ignored; HI ends as the remainder
        run_op("divu_mthi", OP_DIVU, 32'd1000, 32'd7,
               32'd6, 32'd142, 5, OP_MTHI, 32'hAAAA_5555);

        move("mtlo", OP_MTLO, 32'h0000_1234);
        move("mthi", OP_MTHI, 32'h5A5A_0F0F);
        move("badop", 5'b00000, 32'hFFFF_0000);

        // Reset in the middle of a MULT: abort, clear HI/LO, no done
        @(negedge clk);
        alucontrol = OP_MULT;
        srca       = 32'd7;
        srcb       = 32'd9;
        start      = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("abort busy@%0d", k), 64'(busy), 64'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_hi = '0;
        model_lo = '0;
        chk("abort hi",   64'(hi),   64'd0);
        chk("abort lo",   64'(lo),   64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("abort nodone@%0d", k), 64'(done), 64'd0);
        end

        run_op("multu_3_4", OP_MULTU, 32'd3, 32'd4,
               32'd0, 32'd12, 0, 5'd0, '0);

        chk("sb empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
